// File: rtl/mdu_ctrl.sv
// Sequencer for the EX-stage multiplier/divider: issues operands, stalls EX
// until the product or quotient exists, then writes HI/LO exactly once.
module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        stall_ex_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             signed_q;
    logic             div_start_q;
    logic             div_annul_q;
    logic             hilo_we_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    // Only exact one-hot encodings are real operations; anything else is ignored.
    logic is_mul;
    logic is_div;
    assign is_mul = (op_i == 4'b1000) || (op_i == 4'b0100);
    assign is_div = (op_i == 4'b0010) || (op_i == 4'b0001);

    assign stallreq_o = ((state_q == IDLE) && (is_mul || is_div) && !annul_i)
                      || (state_q == MUL_WAIT) || (state_q == DIV_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            div_start_q <= 1'b0;
            div_annul_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            hilo_we_q   <= 1'b0;
            div_annul_q <= 1'b0;
            // A flush wins over everything, including a same-cycle divider ready.
            if (annul_i) begin
                if (state_q == DIV_WAIT) begin
                    div_annul_q <= 1'b1;
                end
                div_start_q <= 1'b0;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_mul || is_div) begin
                            a_q      <= src_a_i;
                            b_q      <= src_b_i;
                            signed_q <= op_i[3] | op_i[1];
                            if (is_mul) begin
                                cnt_q   <= CNT_INIT;
                                state_q <= MUL_WAIT;
                            end else begin
                                div_start_q <= 1'b1;
                                state_q     <= DIV_WAIT;
                            end
                        end
                    end
                    MUL_WAIT: begin
                        if (cnt_q == '0) begin
                            hi_q      <= mul_result_i[63:32];
                            lo_q      <= mul_result_i[31:0];
                            hilo_we_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    DIV_WAIT: begin
                        if (div_ready_i) begin
                            div_start_q <= 1'b0;
                            hi_q        <= div_result_i[63:32];
                            lo_q        <= div_result_i[31:0];
                            hilo_we_q   <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                    DONE: begin
                        // Hold here while EX is frozen so the same op is not re-issued.
                        if (!stall_ex_i) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mul_signed_o = signed_q;
    assign mul_a_o      = a_q;
    assign mul_b_o      = b_q;
    assign div_signed_o = signed_q;
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign div_start_o  = div_start_q;
    assign div_annul_o  = div_annul_q;
    assign hilo_we_o    = hilo_we_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with behavioural multiplier and divider models.
module tb_mdu_ctrl;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] sa;
    logic [31:0] sb;
    logic        stall_ex;
    logic        annul;
    logic        stallreq;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_res;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ready;
    logic [63:0] div_res;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op),
        .src_a_i      (sa),
        .src_b_i      (sb),
        .stall_ex_i   (stall_ex),
        .annul_i      (annul),
        .stallreq_o   (stallreq),
        .mul_signed_o (mul_signed),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_result_i (mul_res),
        .div_start_o  (div_start),
        .div_annul_o  (div_annul),
        .div_signed_o (div_signed),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .div_ready_i  (div_ready),
        .div_result_i (div_res),
        .hilo_we_o    (hilo_we),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    // Multiplier model: product available as soon as operands are.
    always_comb begin
        if (mul_signed)
            mul_res = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        else
            mul_res = {32'b0, mul_a} * {32'b0, mul_b};
    end

    // Divider model: result {rem,quot}, ready pulses DIV_CYC+1 cycles after start.
    int dcnt;
    always_comb begin
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        div_res = '0;
        sq = '0;
        sr = '0;
        if (div_b != 32'd0) begin
            if (div_signed) begin
                sq = $signed(div_a) / $signed(div_b);
                sr = $signed(div_a) % $signed(div_b);
                div_res = {sr, sq};
            end else begin
                div_res = {div_a % div_b, div_a / div_b};
            end
        end
    end

    always @(posedge clk) begin
        if (rst || !div_start || div_annul) begin
            dcnt      <= 0;
            div_ready <= 1'b0;
        end else begin
            div_ready <= (dcnt == int'(DIV_CYC));
            if (dcnt <= int'(DIV_CYC)) dcnt <= dcnt + 1;
        end
    end

    always @(posedge clk) begin
        if (hilo_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and run until the stall request drops (the DONE cycle).
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_sgn, output int stalls, output bit start_ok,
                         output bit sgn_ok);
        op = o;
        sa = a;
        sb = b;
        #1;
        stalls   = 0;
        start_ok = 1'b1;
        sgn_ok   = 1'b1;
        while (stallreq && stalls < 200) begin
            stalls++;
            step();
            if (stallreq) begin
                if (div_start !== 1'b1) start_ok = 1'b0;
                if (div_signed !== exp_sgn) sgn_ok = 1'b0;
            end
        end
    endtask

    initial begin
        int  stalls;
        bit  start_ok;
        bit  sgn_ok;
        int  we0;

        rst = 1'b1; op = '0; sa = '0; sb = '0; stall_ex = 1'b0; annul = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_stallreq", 64'(stallreq), 64'd0);
        check("rst_we", 64'(hilo_we), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ops", {div_a, div_b}, 64'd0);
        check("rst_ctl", {61'd0, div_start, div_annul, mul_signed}, 64'd0);

        // Multi-hot op is ignored, and a flushed op is not issued.
        we0 = we_cnt;
        op = 4'b1010; sa = 32'd5; sb = 32'd6;
        #1;
        check("multihot_stall", 64'(stallreq), 64'd0);
        step();
        check("multihot_idle", 64'(stallreq), 64'd0);
        op = 4'b1000; annul = 1'b1;
        #1;
        check("annul_idle_stall", 64'(stallreq), 64'd0);
        step();
        op = '0; annul = 1'b0;
        step();
        check("annul_idle_nowe", 64'(we_cnt - we0), 64'd0);
        check("annul_idle_ops", 64'(mul_a), 64'd0);

        // 1: mult -3*5
        we0 = we_cnt;
        do_op(4'b1000, 32'hFFFF_FFFD, 32'd5, 1'b1, stalls, start_ok, sgn_ok);
        check("t1_stalls", 64'(stalls), 64'(MUL_LAT + 1));
        check("t1_we", 64'(hilo_we), 64'd1);
        check("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        op = '0;
        step();
        check("t1_we_off", 64'(hilo_we), 64'd0);
        step();
        check("t1_we_cnt", 64'(we_cnt - we0), 64'd1);

        // 2: divu 100/7
        we0 = we_cnt;
        do_op(4'b0001, 32'd100, 32'd7, 1'b0, stalls, start_ok, sgn_ok);
        check("t2_stalls", 64'(stalls), 64'(DIV_CYC + 3));
        check("t2_start_held", 64'(start_ok), 64'd1);
        check("t2_start_off", 64'(div_start), 64'd0);
        check("t2_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
        op = '0;
        step();
        step();
        check("t2_we_cnt", 64'(we_cnt - we0), 64'd1);

        // 3: div -7/2
        do_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 1'b1, stalls, start_ok, sgn_ok);
        check("t3_signed", 64'(sgn_ok), 64'd1);
        check("t3_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        op = '0;
        step();

        // 4: back-to-back divu 9/4 with EX frozen one cycle in DONE
        we0 = we_cnt;
        do_op(4'b0001, 32'd9, 32'd4, 1'b0, stalls, start_ok, sgn_ok);
        check("t4a_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
        stall_ex = 1'b1;
        step();
        check("t4_done_hold_stall", 64'(stallreq), 64'd0);
        check("t4_done_hold_we", 64'(hilo_we), 64'd0);
        stall_ex = 1'b0;
        step();
        do_op(4'b0001, 32'd9, 32'd4, 1'b0, stalls, start_ok, sgn_ok);
        check("t4b_stalls", 64'(stalls), 64'(DIV_CYC + 3));
        check("t4b_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
        op = '0;
        step();
        step();
        check("t4_we_cnt", 64'(we_cnt - we0), 64'd2);

        // 5: annul 5 cycles into a divide
        we0 = we_cnt;
        op = 4'b0001; sa = 32'd50; sb = 32'd3;
        for (int i = 0; i < 5; i++) step();
        check("t5_busy", {62'd0, stallreq, div_start}, 64'd3);
        annul = 1'b1;
        op = '0;
        step();
        annul = 1'b0;
        #1;
        check("t5_annul_pulse", 64'(div_annul), 64'd1);
        check("t5_start_drop", 64'(div_start), 64'd0);
        check("t5_stall_drop", 64'(stallreq), 64'd0);
        step();
        check("t5_annul_off", 64'(div_annul), 64'd0);
        for (int i = 0; i < DIV_CYC + 4; i++) step();
        check("t5_no_we", 64'(we_cnt - we0), 64'd0);
        check("t5_hilo_kept", {hi, lo}, 64'h0000_0001_0000_0002);

        // 6: reset mid MUL_WAIT, then multu 3*4
        we0 = we_cnt;
        op = 4'b0100; sa = 32'd7; sb = 32'd9;
        step();
        rst = 1'b1;
        op = '0;
        step();
        check("t6_rst_hilo", {hi, lo}, 64'd0);
        check("t6_rst_ops", {mul_a, mul_b}, 64'd0);
        check("t6_rst_ctl", {61'd0, hilo_we, stallreq, div_start}, 64'd0);
        rst = 1'b0;
        step();
        check("t6_rst_nowe", 64'(we_cnt - we0), 64'd0);
        do_op(4'b0100, 32'd3, 32'd4, 1'b0, stalls, start_ok, sgn_ok);
        check("t6_stalls", 64'(stalls), 64'(MUL_LAT + 1));
        check("t6_signed", 64'(mul_signed), 64'd0);
        check("t6_hilo", {hi, lo}, 64'h0000_0000_0000_000C);
        op = '0;
        step();
        step();
        check("t6_we_cnt", 64'(we_cnt - we0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
